stopwatch_1: RTL

- Count-up companion to the countdown timer: an elapsed-time stopwatch.
- Clocked by the same clk_1Hz divider output and driven by the same switch and debouncer set.
- Counts HH:MM:SS upward from 00:00:00 and supports pause/resume and a lap capture that freezes the display while counting continues.
- Saturates at a configurable hour limit.
- Outputs feed the same display path as the timer (5-bit hours, 6-bit minutes, 6-bit seconds).

---
 rtl/stopwatch_1.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_1.sv
// Elapsed-time stopwatch: counts HH:MM:SS upward on the 1 Hz clock with pause/resume,
// a lap capture that freezes the display while counting continues, and saturation at HOUR_MAX:59:59.
module stopwatch_1 #(
  parameter int unsigned HOUR_MAX = 12
) (
  input  logic       clk_1Hz,
  input  logic       resetn,
  input  logic       mode_in,
  input  logic       start_stop,
  input  logic       lap_in,
  input  logic       clear_in,
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);

  localparam logic [4:0] HOUR_LIM = 5'(HOUR_MAX);
  localparam logic [5:0] LAST_MS  = 6'd59;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_MAXED = 2'd3
  } state_t;

  state_t     r_state;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [4:0] r_hour;
  logic [5:0] r_lap_sec;
  logic [5:0] r_lap_min;
  logic [4:0] r_lap_hour;
  logic       r_lap_hold;
  logic       r_running;
  logic       r_overflow;
  logic       r_lap_d;
  logic       r_clr_d;

  logic       w_lap_req;
  logic       w_clr_req;
  logic       w_at_max;
  logic [5:0] w_sec_nx;
  logic [5:0] w_min_nx;
  logic [4:0] w_hour_nx;

  // Rising-edge requests: a held button produces exactly one request.
  assign w_lap_req = lap_in & ~r_lap_d;
  assign w_clr_req = clear_in & ~r_clr_d;

  assign w_at_max = (r_hour == HOUR_LIM) && (r_min == LAST_MS) && (r_sec == LAST_MS);

  // Carry chain; the hour never passes HOUR_LIM because the counter stops at the max value.
  always_comb begin
    w_sec_nx  = r_sec;
    w_min_nx  = r_min;
    w_hour_nx = r_hour;
    if (r_sec == LAST_MS) begin
      w_sec_nx = 6'd0;
      if (r_min == LAST_MS) begin
        w_min_nx  = 6'd0;
        w_hour_nx = r_hour + 5'd1;
      end else begin
        w_min_nx = r_min + 6'd1;
      end
    end else begin
      w_sec_nx = r_sec + 6'd1;
    end
  end

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_sec      <= 6'd0;
      r_min      <= 6'd0;
      r_hour     <= 5'd0;
      r_lap_sec  <= 6'd0;
      r_lap_min  <= 6'd0;
      r_lap_hour <= 5'd0;
      r_lap_hold <= 1'b0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
      r_lap_d    <= 1'b0;
      r_clr_d    <= 1'b0;
    end else begin
      r_lap_d <= lap_in;
      r_clr_d <= clear_in;
      if (!mode_in || ((r_state == S_PAUSE || r_state == S_MAXED) && w_clr_req)) begin
        r_state    <= S_IDLE;
        r_sec      <= 6'd0;
        r_min      <= 6'd0;
        r_hour     <= 5'd0;
        r_lap_sec  <= 6'd0;
        r_lap_min  <= 6'd0;
        r_lap_hour <= 5'd0;
        r_lap_hold <= 1'b0;
        r_running  <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_stop) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          S_RUN: begin
            // Lap captures the pre-increment value; pausing on the same edge still counts once.
            if (w_lap_req) begin
              if (r_lap_hold) begin
                r_lap_hold <= 1'b0;
              end else begin
                r_lap_sec  <= r_sec;
                r_lap_min  <= r_min;
                r_lap_hour <= r_hour;
                r_lap_hold <= 1'b1;
              end
            end
            if (w_at_max) begin
              r_state    <= S_MAXED;
              r_running  <= 1'b0;
              r_overflow <= 1'b1;
            end else begin
              r_sec  <= w_sec_nx;
              r_min  <= w_min_nx;
              r_hour <= w_hour_nx;
              if (!start_stop) begin
                r_state   <= S_PAUSE;
                r_running <= 1'b0;
              end
            end
          end
          S_PAUSE: begin
            if (start_stop) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
            if (w_lap_req) begin
              r_lap_hold <= 1'b0;
            end
          end
          S_MAXED: begin
            if (w_lap_req) begin
              r_lap_hold <= 1'b0;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hour_out = r_lap_hold ? r_lap_hour : r_hour;
  assign min_out  = r_lap_hold ? r_lap_min  : r_min;
  assign sec_out  = r_lap_hold ? r_lap_sec  : r_sec;
  assign running  = r_running;
  assign lap_hold = r_lap_hold;
  assign overflow = r_overflow;

endmodule
